// File: rtl/vedic_div8by4_pkg.sv
// Shared widths and FSM state encoding for the vedic_div8by4 restoring divider.
package vedic_div8by4_pkg;

    localparam int DIVW_DEF  = 8;
    localparam int DIVSW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/vedic_div8by4_if.sv
// Operand/result handshake bundle for vedic_div8by4; chk_err exists only with VEDIC_DIV_SELFCHECK_EN.
interface vedic_div8by4_if
    import vedic_div8by4_pkg::*;
#(
    parameter int DIVW  = DIVW_DEF,
    parameter int DIVSW = DIVSW_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [DIVW-1:0]  dividend;
    logic [DIVSW-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [DIVW-1:0]  quotient;
    logic [DIVSW-1:0] remainder;
    logic             div_by_zero;
`ifdef VEDIC_DIV_SELFCHECK_EN
    logic             chk_err;
`endif

    modport master (
`ifdef VEDIC_DIV_SELFCHECK_EN
        input  chk_err,
`endif
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
`ifdef VEDIC_DIV_SELFCHECK_EN
        output chk_err,
`endif
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/vedic_div8by4_step.sv
// One combinational restoring-division step: shift in a dividend bit, try to subtract the divisor.
module vedic_div_step #(
    parameter int DIVSW = 4
) (
    input  logic [DIVSW:0]   i_rem,
    input  logic             i_bit,
    input  logic [DIVSW-1:0] i_divisor,
    output logic [DIVSW:0]   o_rem,
    output logic             o_qbit
);
    logic [DIVSW+1:0] w_shift;
    logic [DIVSW:0]   w_diff;

    // When the subtraction succeeds the true difference is below the divisor, so DIVSW+1 bits suffice.
    always_comb begin
        w_shift = {i_rem, i_bit};
        o_qbit  = (w_shift >= {2'b00, i_divisor});
        w_diff  = w_shift[DIVSW:0] - {1'b0, i_divisor};
        o_rem   = o_qbit ? w_diff : w_shift[DIVSW:0];
    end

endmodule

// File: rtl/vedic_div8by4.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional macro VEDIC_DIV_SELFCHECK_EN adds a quotient*divisor+remainder check on chk_err.
module vedic_div8by4
    import vedic_div8by4_pkg::*;
#(
    parameter int DIVW  = DIVW_DEF,
    parameter int DIVSW = DIVSW_DEF
) (
    input logic            clk,
    input logic            rst,
    vedic_div8by4_if.slave bus
);
    localparam int CNTW = (DIVW > 1) ? $clog2(DIVW) : 1;

    state_t           r_state;
    logic [CNTW-1:0]  r_cnt;
    logic [DIVW-1:0]  r_work;
    logic [DIVSW-1:0] r_divisor;
    logic [DIVSW:0]   r_prem;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [DIVW-1:0]  r_quotient;
    logic [DIVSW-1:0] r_remainder;
    logic             r_dbz;
    logic [DIVSW:0]   w_prem_next;
    logic             w_qbit;

    vedic_div_step #(.DIVSW(DIVSW)) u_step (
        .i_rem     (r_prem),
        .i_bit     (r_work[DIVW-1]),
        .i_divisor (r_divisor),
        .o_rem     (w_prem_next),
        .o_qbit    (w_qbit)
    );

`ifdef VEDIC_DIV_SELFCHECK_EN
    logic [DIVW-1:0]       r_dividend;
    logic                  r_chk_err;
    logic [DIVW+DIVSW-1:0] w_recon;
    logic                  w_mismatch;

    always_comb begin
        w_recon    = ({{DIVSW{1'b0}}, r_work} * {{DIVW{1'b0}}, r_divisor})
                   + {{DIVW{1'b0}}, r_prem[DIVSW-1:0]};
        w_mismatch = (r_divisor != '0) && (w_recon != {{DIVSW{1'b0}}, r_dividend});
    end

    assign bus.chk_err = r_chk_err;
`endif

    // r_work starts as the dividend and fills with quotient bits as its MSBs are shifted out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_work      <= '0;
            r_divisor   <= '0;
            r_prem      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
`ifdef VEDIC_DIV_SELFCHECK_EN
            r_dividend  <= '0;
            r_chk_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_work     <= bus.dividend;
                        r_divisor  <= bus.divisor;
                        r_prem     <= '0;
                        r_in_ready <= 1'b0;
`ifdef VEDIC_DIV_SELFCHECK_EN
                        r_dividend <= bus.dividend;
`endif
                        if (bus.divisor == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= RUN;
                            r_cnt   <= CNTW'(DIVW - 1);
                        end
                    end
                end
                RUN: begin
                    r_prem <= w_prem_next;
                    r_work <= {r_work[DIVW-2:0], w_qbit};
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // The first DONE cycle publishes the result; later cycles wait for the consumer.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        if (r_divisor == '0) begin
                            r_quotient  <= '1;
                            r_remainder <= r_work[DIVSW-1:0];
                            r_dbz       <= 1'b1;
`ifdef VEDIC_DIV_SELFCHECK_EN
                            r_chk_err   <= 1'b0;
`endif
                        end else begin
                            r_quotient  <= r_work;
                            r_remainder <= r_prem[DIVSW-1:0];
                            r_dbz       <= 1'b0;
`ifdef VEDIC_DIV_SELFCHECK_EN
                            r_chk_err   <= w_mismatch;
`endif
                        end
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
`ifdef VEDIC_DIV_SELFCHECK_EN
                        r_chk_err   <= 1'b0;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: doc/vedic_div8by4.md
Name: vedic_div8by4

Overview:
- Sequential restoring divider that inverts the 4-bit vedic multiplier: a DIVW-bit dividend divided by a DIVSW-bit divisor yields a quotient and a remainder.
- Used where an 8-bit product must be split back into factors, or for general small-width division in the arithmetic datapath.
- Valid/ready handshake on both input and output; computes one quotient bit per clock.

Parameters:
- DIVW, 8, dividend and quotient width
- DIVSW, 4, divisor and remainder width (DIVSW <= DIVW)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operand pair offered
- in_ready  output  1  block can accept operands (IDLE only)
- dividend  input  DIVW  numerator, unsigned
- divisor  input  DIVSW  denominator, unsigned
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- quotient  output  DIVW  unsigned quotient
- remainder  output  DIVSW  unsigned remainder, always < divisor when divisor != 0
- div_by_zero  output  1  result is for a zero divisor
- chk_err  output  1  self-check mismatch (present only with VEDIC_DIV_SELFCHECK_EN)

Behaviour:
- Reset (async, active-high):
  - State = IDLE; in_ready=1; out_valid=0.
  - quotient=0, remainder=0, div_by_zero=0, chk_err=0.
  - Iteration counter = 0.
- States:
  - IDLE:
    - in_ready=1.
    - in_valid=1 with divisor != 0: latch operands, clear the partial remainder (DIVSW+1 bits), go to RUN, counter=DIVW-1.
    - in_valid=1 with divisor == 0: go straight to DONE with quotient = all ones, remainder = dividend[DIVSW-1:0], div_by_zero=1.
  - RUN:
    - Each cycle: shift {partial remainder, dividend MSB}; subtract divisor. If the difference is non-negative, keep it and shift 1 into the quotient; otherwise restore and shift 0.
    - Stays for exactly DIVW cycles; counter decrements, and leaves at counter==0.
  - DONE:
    - out_valid=1; quotient, remainder and div_by_zero are held stable.
    - Return to IDLE on the cycle out_valid && out_ready.
- Latency:
  - Operand accept at edge N -> out_valid high after edge N+DIVW+1 (9 cycles for DIVW=8).
  - Divide-by-zero: out_valid after edge N+1.
- Throughput:
  - One operation in flight. in_ready=0 in RUN and DONE.
  - The earliest next accept is the cycle after the result handshake; there is no same-cycle result-pop plus operand-push.
- Outputs are registered. Result outputs change only on entry to DONE; they keep their last values in IDLE and RUN.
- Operands are unsigned; there is no overflow case, because quotient <= dividend always fits in DIVW bits.
- Backpressure: out_ready may stay low indefinitely; all outputs are held.
- Reset mid-RUN or mid-DONE aborts immediately to reset values. The pending result is lost.
- in_valid while in_ready=0 is ignored; operand changes during RUN have no effect.

Optional Feature:
- Macro: VEDIC_DIV_SELFCHECK_EN.
- Defined:
  - On entry to DONE with a non-zero divisor, compute quotient*divisor + remainder (DIVW+DIVSW bits, zero-extended) and compare it with the latched dividend.
  - chk_err=1 on mismatch, held with the result and cleared on the handshake.
  - For divide-by-zero results, chk_err=0.
- Undefined: the chk_err port is absent and no check logic is built.

Decomposition:
- Shared package/header holds:
  - DIVW/DIVSW defaults.
  - State encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- One sub-module, vedic_div_step: the combinational restoring step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: next partial remainder, quotient bit.
  - Instantiated once and reused every cycle.

Test Plan:
- Reset then 200/13 (0xC8/0xD) with out_ready=1 -> out_valid 9 cycles after accept; quotient=15, remainder=5, div_by_zero=0, chk_err=0.
- 255/1 -> quotient=255, remainder=0; 7/9 -> quotient=0, remainder=7; 225/15 -> quotient=15, remainder=0.
- 0xA7/0 -> out_valid after 1 cycle; quotient=0xFF, remainder=0x7, div_by_zero=1; the next normal divide clears div_by_zero.
- Backpressure on 100/7: hold out_ready=0 for 5 cycles after out_valid -> quotient=14, remainder=2 held stable, in_ready=0, new in_valid ignored; result pops only when out_ready=1.
- Assert rst at the 4th RUN cycle of 99/4 -> all outputs at reset values immediately (async), in_ready=1 after release. A following 99/4 gives quotient=24, remainder=3.
- Exhaustive: all 256x15 non-zero pairs back-to-back with random out_ready -> results match a reference model; chk_err never asserted.
